fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the five-stage MIPS pipeline. It sits upstream of decode and feeds it. It owns the PC register, issues word requests to the instruction cache and absorbs multi-cycle cache misses. It also handles branch/jump redirects from ID and downstream stalls, and presents a registered instruction with its PC+4 to the decode stage.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- stall_i  in  1  downstream hold (hazard unit / data-cache stall); freezes outputs.
- redirect_i  in  1  taken branch/jump from ID; one-cycle pulse.
- redirect_pc_i  in  32  redirect target; bits [1:0] ignored (treated as 00).
- ICACHE_ren  out  1  cache read request.
- ICACHE_wen  out  1  tied 0.
- ICACHE_addr  out  30  word address, PC[31:2].
- ICACHE_wdata  out  32  tied 0.
- ICACHE_stall  in  1  cache busy; data valid in the cycle ren=1 and stall=0.
- ICACHE_rdata  in  32  fetched word.
- PC_4  out  32  PC+4 of the presented instruction.
- inst  out  32  presented instruction; 32'h0 (NOP) when not valid.
- inst_valid  out  1  inst/PC_4 hold a real instruction.

## Operation
- Registers:
  - pc, the fetch address.
  - tgt, the pending redirect target.
  - skid, plus skid_pc4, a one-entry hold buffer.
  - state, the FSM state.
  - output registers.
- FSM states: FETCH, WAIT, HOLD, DISCARD.
- FETCH:
  - ICACHE_ren = ~stall_i; addr = pc[31:2].
  - ren & ~ICACHE_stall is a completion: inst<=rdata, PC_4<=pc+4, inst_valid<=1, pc<=pc+4; stay in FETCH.
  - ren & ICACHE_stall: go to WAIT.
  - ~stall_i with no completion: inst_valid<=0, inst<=0.
- WAIT:
  - ren=1; addr held at pc.
  - On ~ICACHE_stall with ~stall_i: perform the completion as in FETCH, then go to FETCH.
  - On ~ICACHE_stall with stall_i: skid<=rdata, skid_pc4<=pc+4, go to HOLD; outputs unchanged.
- HOLD:
  - ren=0.
  - On ~stall_i: inst<=skid, PC_4<=skid_pc4, inst_valid<=1, pc<=pc+4, go to FETCH.
- DISCARD:
  - ren=1; addr = old pc, kept stable until the cache finishes.
  - On ~ICACHE_stall: data dropped, pc<=tgt, go to FETCH.
- Redirect has highest priority and overrides stall_i. On redirect:
  - inst_valid<=0 and inst<=0.
  - In FETCH: pc<=redirect_pc, except when ICACHE_stall=1 with ren=1, which goes to DISCARD with tgt<=redirect_pc.
  - In HOLD: skid dropped, pc<=redirect_pc, go to FETCH.
  - In WAIT: tgt<=redirect_pc, go to DISCARD.
  - In DISCARD: tgt overwritten (newest target wins). If the cache completes in the same cycle, pc<=redirect_pc and go to FETCH.
- Arithmetic:
  - pc+4 is 32-bit and wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
  - pc[1:0] is always 00.
- ren and addr are never changed while a request is outstanding (ren=1 and ICACHE_stall=1).

## Timing
- Reset values:
  - pc=RESET_PC, state=FETCH, tgt=0, skid=0, skid_pc4=0.
  - inst=0, PC_4=0, inst_valid=0.
  - ICACHE_ren follows the FETCH rule from the first cycle after reset.
- Reset mid-miss: the outstanding request is abandoned and the next request goes to RESET_PC. The cache must tolerate this.
- Hit latency: the instruction is at the outputs one cycle after the request cycle. Throughput is 1 instruction per cycle.
- Miss of N stall cycles: the output shows a bubble (inst_valid=0) for N cycles, then the instruction.
- The first request after a redirect is issued in the following cycle. Redirect penalty is 1 bubble with no outstanding miss, more if in DISCARD.
- While stall_i=1, inst, PC_4 and inst_valid are held exactly, unless a redirect occurs.

## Structure
- Shared package cpu_pkg:
  - fetch-state enum (FETCH, WAIT, HOLD, DISCARD).
  - NOP_INST = 32'h0.
  - default RESET_PC constant.
- Single module, no sub-module. FSM, PC incrementer and skid buffer are all inline.

## Test plan
- Reset, always-hit cache with rdata=addr<<2: inst_valid rises the cycle after the first request. PC_4 sequence is 4, 8, 12, …, one per cycle.
- Miss at pc=0x10, ICACHE_stall high for 3 cycles: addr stays 0x4 throughout, 3 bubbles, then inst at PC_4=0x14.
- redirect_i to 0x100 during the second miss cycle: miss completes with data discarded, next request addr=0x40, no valid output from the old word.
- stall_i high in the cycle the miss completes, held 2 more cycles: ren=0 in HOLD, outputs frozen. The skid word appears the cycle after stall_i falls.
- redirect_i and stall_i together in FETCH with hit: inst_valid=0 next cycle and pc=target (redirect wins). pc=32'hFFFF_FFFC then hit: next PC_4=0.
- rst_n low during a miss: next cycle pc=RESET_PC, inst_valid=0, state FETCH.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, the NOP encoding and the default
// reset vector used by the instruction-fetch stage.
package cpu_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_WAIT    = 2'd1,
    ST_HOLD    = 2'd2,
    ST_DISCARD = 2'd3
  } fetch_state_t;

  // Sequential PC step; wraps modulo 2^32.
  function automatic logic [31:0] pcPlus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, talks to the I-cache, absorbs misses,
// redirects and downstream stalls, and presents a registered instruction to ID.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        ICACHE_ren,
  output logic        ICACHE_wen,
  output logic [29:0] ICACHE_addr,
  output logic [31:0] ICACHE_wdata,
  input  logic        ICACHE_stall,
  input  logic [31:0] ICACHE_rdata,
  output logic [31:0] PC_4,
  output logic [31:0] inst,
  output logic        inst_valid
);

  localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_tgt;
  logic [31:0]  r_skid;
  logic [31:0]  r_skidPc4;
  logic [31:0]  r_inst;
  logic [31:0]  r_pc4;
  logic         r_valid;

  fetch_state_t w_nextState;
  logic [31:0]  w_nextPc;
  logic [31:0]  w_nextTgt;
  logic [31:0]  w_nextSkid;
  logic [31:0]  w_nextSkidPc4;
  logic [31:0]  w_nextInst;
  logic [31:0]  w_nextPc4;
  logic         w_nextValid;
  logic         w_ren;
  logic [31:0]  w_redirPc;
  logic [31:0]  w_pcPlus4;

  assign w_redirPc = redirect_pc_i & PC_MASK;
  assign w_pcPlus4 = pcPlus4(r_pc);

  // Next-state, PC, skid and output-register logic; everything holds by default.
  always_comb begin
    w_nextState   = r_state;
    w_nextPc      = r_pc;
    w_nextTgt     = r_tgt;
    w_nextSkid    = r_skid;
    w_nextSkidPc4 = r_skidPc4;
    w_nextInst    = r_inst;
    w_nextPc4     = r_pc4;
    w_nextValid   = r_valid;
    w_ren         = 1'b0;

    case (r_state)
      ST_FETCH: begin
        w_ren = ~stall_i;
        if (redirect_i) begin
          w_nextInst  = NOP_INST;
          w_nextValid = 1'b0;
          // A request that the cache has accepted but not finished must drain first.
          if (!stall_i && ICACHE_stall) begin
            w_nextTgt   = w_redirPc;
            w_nextState = ST_DISCARD;
          end else begin
            w_nextPc = w_redirPc;
          end
        end else if (!stall_i && !ICACHE_stall) begin
          w_nextInst  = ICACHE_rdata;
          w_nextPc4   = w_pcPlus4;
          w_nextValid = 1'b1;
          w_nextPc    = w_pcPlus4;
        end else if (!stall_i) begin
          w_nextInst  = NOP_INST;
          w_nextValid = 1'b0;
          w_nextState = ST_WAIT;
        end
      end

      ST_WAIT: begin
        w_ren = 1'b1;
        if (redirect_i) begin
          w_nextInst  = NOP_INST;
          w_nextValid = 1'b0;
          w_nextTgt   = w_redirPc;
          w_nextState = ST_DISCARD;
        end else if (!ICACHE_stall) begin
          if (!stall_i) begin
            w_nextInst  = ICACHE_rdata;
            w_nextPc4   = w_pcPlus4;
            w_nextValid = 1'b1;
            w_nextPc    = w_pcPlus4;
            w_nextState = ST_FETCH;
          end else begin
            w_nextSkid    = ICACHE_rdata;
            w_nextSkidPc4 = w_pcPlus4;
            w_nextState   = ST_HOLD;
          end
        end else if (!stall_i) begin
          w_nextInst  = NOP_INST;
          w_nextValid = 1'b0;
        end
      end

      ST_HOLD: begin
        if (redirect_i) begin
          w_nextInst  = NOP_INST;
          w_nextValid = 1'b0;
          w_nextPc    = w_redirPc;
          w_nextState = ST_FETCH;
        end else if (!stall_i) begin
          w_nextInst  = r_skid;
          w_nextPc4   = r_skidPc4;
          w_nextValid = 1'b1;
          w_nextPc    = w_pcPlus4;
          w_nextState = ST_FETCH;
        end
      end

      ST_DISCARD: begin
        w_ren = 1'b1;
        if (redirect_i) begin
          w_nextInst  = NOP_INST;
          w_nextValid = 1'b0;
          if (!ICACHE_stall) begin
            w_nextPc    = w_redirPc;
            w_nextState = ST_FETCH;
          end else begin
            w_nextTgt = w_redirPc;
          end
        end else if (!ICACHE_stall) begin
          w_nextPc    = r_tgt;
          w_nextState = ST_FETCH;
        end
      end

      default: begin
        w_nextState = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_FETCH;
      r_pc      <= RESET_PC & PC_MASK;
      r_tgt     <= 32'h0;
      r_skid    <= 32'h0;
      r_skidPc4 <= 32'h0;
      r_inst    <= NOP_INST;
      r_pc4     <= 32'h0;
      r_valid   <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_pc      <= w_nextPc;
      r_tgt     <= w_nextTgt;
      r_skid    <= w_nextSkid;
      r_skidPc4 <= w_nextSkidPc4;
      r_inst    <= w_nextInst;
      r_pc4     <= w_nextPc4;
      r_valid   <= w_nextValid;
    end
  end

  assign ICACHE_ren   = w_ren;
  assign ICACHE_wen   = 1'b0;
  assign ICACHE_addr  = r_pc[31:2];
  assign ICACHE_wdata = 32'h0;
  assign PC_4         = r_pc4;
  assign inst         = r_inst;
  assign inst_valid   = r_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit. The I-cache model returns the
// byte address of the requested word, so a fetched instruction equals its PC.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        ICACHE_ren;
  logic        ICACHE_wen;
  logic [29:0] ICACHE_addr;
  logic [31:0] ICACHE_wdata;
  logic        ICACHE_stall;
  logic [31:0] ICACHE_rdata;
  logic [31:0] PC_4;
  logic [31:0] inst;
  logic        inst_valid;

  int compared   = 0;
  int mismatched = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .ICACHE_ren    (ICACHE_ren),
    .ICACHE_wen    (ICACHE_wen),
    .ICACHE_addr   (ICACHE_addr),
    .ICACHE_wdata  (ICACHE_wdata),
    .ICACHE_stall  (ICACHE_stall),
    .ICACHE_rdata  (ICACHE_rdata),
    .PC_4          (PC_4),
    .inst          (inst),
    .inst_valid    (inst_valid)
  );

  always #5 clk = ~clk;

  assign ICACHE_rdata = {ICACHE_addr, 2'b00};

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        cst;
    logic        expRen;
    logic [29:0] expAddr;
    logic        expValid;
    logic [31:0] expInst;
    logic [31:0] expPc4;
  } vec_t;

  localparam int NV = 37;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rp,
                              input logic c, input logic er, input logic [29:0] ea,
                              input logic ev, input logic [31:0] ei, input logic [31:0] ep);
    vec_t v;
    v.stall = s; v.redir = r; v.rpc = rp; v.cst = c;
    v.expRen = er; v.expAddr = ea; v.expValid = ev; v.expInst = ei; v.expPc4 = ep;
    return v;
  endfunction

  task automatic applyStimulus(input logic s, input logic r, input logic [31:0] rp, input logic c);
    stall_i       = s;
    redirect_i    = r;
    redirect_pc_i = rp;
    ICACHE_stall  = c;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    //              stall redir rpc           cst  ren addr          valid inst          pc4
    vecs[0]  = mk(0, 0, 32'h0,        0, 1, 30'h0,        1, 32'h0,        32'h4);
    vecs[1]  = mk(0, 0, 32'h0,        0, 1, 30'h1,        1, 32'h4,        32'h8);
    vecs[2]  = mk(0, 0, 32'h0,        0, 1, 30'h2,        1, 32'h8,        32'hC);
    vecs[3]  = mk(0, 0, 32'h0,        0, 1, 30'h3,        1, 32'hC,        32'h10);
    vecs[4]  = mk(0, 0, 32'h0,        1, 1, 30'h4,        0, 32'h0,        32'h10);
    vecs[5]  = mk(0, 0, 32'h0,        1, 1, 30'h4,        0, 32'h0,        32'h10);
    vecs[6]  = mk(0, 0, 32'h0,        1, 1, 30'h4,        0, 32'h0,        32'h10);
    vecs[7]  = mk(0, 0, 32'h0,        0, 1, 30'h4,        1, 32'h10,       32'h14);
    vecs[8]  = mk(0, 0, 32'h0,        1, 1, 30'h5,        0, 32'h0,        32'h14);
    vecs[9]  = mk(0, 1, 32'h100,      1, 1, 30'h5,        0, 32'h0,        32'h14);
    vecs[10] = mk(0, 0, 32'h0,        1, 1, 30'h5,        0, 32'h0,        32'h14);
    vecs[11] = mk(0, 0, 32'h0,        0, 1, 30'h5,        0, 32'h0,        32'h14);
    vecs[12] = mk(0, 0, 32'h0,        0, 1, 30'h40,       1, 32'h100,      32'h104);
    vecs[13] = mk(0, 0, 32'h0,        1, 1, 30'h41,       0, 32'h0,        32'h104);
    vecs[14] = mk(1, 0, 32'h0,        0, 1, 30'h41,       0, 32'h0,        32'h104);
    vecs[15] = mk(1, 0, 32'h0,        0, 0, 30'h41,       0, 32'h0,        32'h104);
    vecs[16] = mk(1, 0, 32'h0,        0, 0, 30'h41,       0, 32'h0,        32'h104);
    vecs[17] = mk(0, 0, 32'h0,        0, 0, 30'h41,       1, 32'h104,      32'h108);
    vecs[18] = mk(1, 0, 32'h0,        0, 0, 30'h42,       1, 32'h104,      32'h108);
    vecs[19] = mk(0, 0, 32'h0,        0, 1, 30'h42,       1, 32'h108,      32'h10C);
    vecs[20] = mk(1, 1, 32'h203,      0, 0, 30'h43,       0, 32'h0,        32'h10C);
    vecs[21] = mk(0, 0, 32'h0,        0, 1, 30'h80,       1, 32'h200,      32'h204);
    vecs[22] = mk(0, 1, 32'hFFFF_FFFC, 0, 1, 30'h81,      0, 32'h0,        32'h204);
    vecs[23] = mk(0, 0, 32'h0,        0, 1, 30'h3FFF_FFFF, 1, 32'hFFFF_FFFC, 32'h0);
    vecs[24] = mk(0, 0, 32'h0,        0, 1, 30'h0,        1, 32'h0,        32'h4);
    vecs[25] = mk(0, 1, 32'h40,       1, 1, 30'h1,        0, 32'h0,        32'h4);
    vecs[26] = mk(0, 1, 32'h80,       1, 1, 30'h1,        0, 32'h0,        32'h4);
    vecs[27] = mk(0, 0, 32'h0,        0, 1, 30'h1,        0, 32'h0,        32'h4);
    vecs[28] = mk(0, 0, 32'h0,        0, 1, 30'h20,       1, 32'h80,       32'h84);
    vecs[29] = mk(0, 0, 32'h0,        1, 1, 30'h21,       0, 32'h0,        32'h84);
    vecs[30] = mk(1, 0, 32'h0,        0, 1, 30'h21,       0, 32'h0,        32'h84);
    vecs[31] = mk(1, 1, 32'h300,      0, 0, 30'h21,       0, 32'h0,        32'h84);
    vecs[32] = mk(0, 0, 32'h0,        0, 1, 30'hC0,       1, 32'h300,      32'h304);
    vecs[33] = mk(0, 0, 32'h0,        1, 1, 30'hC1,       0, 32'h0,        32'h304);
    vecs[34] = mk(0, 1, 32'h500,      1, 1, 30'hC1,       0, 32'h0,        32'h304);
    vecs[35] = mk(0, 1, 32'h600,      0, 1, 30'hC1,       0, 32'h0,        32'h304);
    vecs[36] = mk(0, 0, 32'h0,        0, 1, 30'h180,      1, 32'h600,      32'h604);

    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset inst_valid", {31'b0, inst_valid}, 32'h0);
    checkOutput("reset inst", inst, NOP_INST);
    checkOutput("reset PC_4", PC_4, 32'h0);
    checkOutput("tied wen", {31'b0, ICACHE_wen}, 32'h0);
    checkOutput("tied wdata", ICACHE_wdata, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("reset ren", {31'b0, ICACHE_ren}, 32'h1);
    checkOutput("reset addr", {2'b0, ICACHE_addr}, 32'h0);

    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i].stall, vecs[i].redir, vecs[i].rpc, vecs[i].cst);
      #1;
      checkOutput($sformatf("v%0d ren", i), {31'b0, ICACHE_ren}, {31'b0, vecs[i].expRen});
      checkOutput($sformatf("v%0d addr", i), {2'b0, ICACHE_addr}, {2'b0, vecs[i].expAddr});
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d inst_valid", i), {31'b0, inst_valid}, {31'b0, vecs[i].expValid});
      checkOutput($sformatf("v%0d inst", i), inst, vecs[i].expInst);
      checkOutput($sformatf("v%0d PC_4", i), PC_4, vecs[i].expPc4);
      @(negedge clk);
    end

    // Reset asserted while a miss at 0x604 is outstanding.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    #1;
    checkOutput("midmiss addr", {2'b0, ICACHE_addr}, 32'h181);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midmiss reset inst_valid", {31'b0, inst_valid}, 32'h0);
    checkOutput("midmiss reset inst", inst, 32'h0);
    checkOutput("midmiss reset PC_4", PC_4, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    checkOutput("midmiss ren", {31'b0, ICACHE_ren}, 32'h1);
    checkOutput("midmiss addr after reset", {2'b0, ICACHE_addr}, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("post reset inst_valid", {31'b0, inst_valid}, 32'h1);
    checkOutput("post reset inst", inst, 32'h0);
    checkOutput("post reset PC_4", PC_4, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
